// File: rtl/d_latch_if.sv
// Signal bundle for the gated D latch bank.
// DUT and TEST modports give each side its port directions.
interface d_latch_if #(
    parameter int WIDTH = 1
);
    logic             C;
    logic             rst;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_n;

    modport DUT  (input C, input rst, input D, output Q, output Q_n);
    modport TEST (input Q, input Q_n, output C, output rst, output D);
endinterface

// File: rtl/d_latch.sv
// Bank of WIDTH transparent D latches sharing one gate C, with asynchronous
// active-low clear to RST_VAL and complementary outputs.
module d_latch #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             C,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_n
);
    logic [WIDTH-1:0] q_reg;

    // One storage element per bit; each owns its own local state so that
    // no vector is driven from more than one process.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic bit_reg;

            always_latch begin
                if (!rst) begin
                    bit_reg <= RST_VAL[gi];
                end else if (C) begin
                    bit_reg <= D[gi];
                end
            end

            assign q_reg[gi] = bit_reg;
        end
    endgenerate

    assign Q   = q_reg;
    assign Q_n = ~q_reg;
endmodule

// Adapter so the latch bank can be hooked up through the DUT modport.
module d_latch_port #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    d_latch_if.DUT bus
);
    d_latch #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_latch (
        .C   (bus.C),
        .rst (bus.rst),
        .D   (bus.D),
        .Q   (bus.Q),
        .Q_n (bus.Q_n)
    );
endmodule

// File: tb/tb_d_latch.sv
// Directed bench: a WIDTH=1 and a WIDTH=8 latch on named ports plus a WIDTH=1
// latch hooked up through the interface, all driven from the same stimulus.
module tb_d_latch;
    logic       c;
    logic       rst;
    logic       d1;
    logic [7:0] d8;
    logic       q1, qn1;
    logic [7:0] q8, qn8;

    int tests;
    int failed;

    d_latch #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
        .C(c), .rst(rst), .D(d1), .Q(q1), .Q_n(qn1)
    );

    d_latch #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
        .C(c), .rst(rst), .D(d8), .Q(q8), .Q_n(qn8)
    );

    d_latch_if #(.WIDTH(1)) bus ();
    assign bus.C   = c;
    assign bus.rst = rst;
    assign bus.D   = d1;

    d_latch_port #(.WIDTH(1), .RST_VAL(1'b0)) dut_if (.bus(bus.DUT));

    typedef struct {
        logic       rst;
        logic       c;
        logic       d1;
        logic [7:0] d8;
        logic       q1;
        logic [7:0] q8;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic eq1, input logic [7:0] eq8);
        check({tag, " q1"},    {7'b0, q1},      {7'b0, eq1});
        check({tag, " qn1"},   {7'b0, qn1},     {7'b0, ~eq1});
        check({tag, " q8"},    q8,              eq8);
        check({tag, " qn8"},   qn8,             ~eq8);
        check({tag, " q_if"},  {7'b0, bus.Q},   {7'b0, eq1});
        check({tag, " qn_if"}, {7'b0, bus.Q_n}, {7'b0, ~eq1});
        $display("[TB] %s: rst=%b c=%b d1=%b d8=%h -> q1=%b q8=%h q_if=%b",
                 tag, rst, c, d1, d8, q1, q8, bus.Q);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst = 1'b0; c = 1'b1; d1 = 1'b1; d8 = 8'hFF;

        //            rst   c     d1    d8     q1    q8
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 8'hA5}; // reset dominates gate
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'hA5};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 8'hA5};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'hA5}; // release with gate closed
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C}; // transparent
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 8'h3C};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 8'hC3};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 8'h3C};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h3C}; // capture on C fall
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h3C}; // hold while D toggles
        vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h3C};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h3C};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h3C};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h81, 1'b1, 8'h3C};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 8'h81, 1'b0, 8'h81}; // reopen gate

        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].rst;
            c   = vecs[i].c;
            d1  = vecs[i].d1;
            d8  = vecs[i].d8;
            #5;
            check_all($sformatf("vec%0d", i), vecs[i].q1, vecs[i].q8);
            #5;
        end

        // C rising with D already set: Q follows in the same timestep.
        c = 1'b0; d1 = 1'b1; d8 = 8'h77; #10;
        c = 1'b1; #1;
        check_all("rise", 1'b1, 8'h77);
        #9;

        // Capture 1, then a short reset pulse while closed: Q stays cleared.
        c = 1'b0; #10;
        check_all("held", 1'b1, 8'h77);
        rst = 1'b0; #1;
        check_all("pulse", 1'b0, 8'hA5);
        rst = 1'b1; #1;
        check_all("post_rel", 1'b0, 8'hA5);
        d1 = 1'b0; d8 = 8'h11; #5;
        d1 = 1'b1; d8 = 8'h22; #5;
        check_all("closed_after_rel", 1'b0, 8'hA5);

        // Reset during transparency, then release with gate open.
        c = 1'b1; #1;
        check_all("reopen", 1'b1, 8'h22);
        rst = 1'b0; #1;
        check_all("rst_open", 1'b0, 8'hA5);
        rst = 1'b1; #1;
        check_all("rel_open", 1'b1, 8'h22);
        #10;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
